pll_clockgen: RTL and testbench
===============================

PLL_CLOCKGEN -- requirements
Module: pll

Interface
REQ-001: Parameter LOCK_CYCLES, default 256: number of inclk0 rising edges after reset release before lock is declared; legal range 1..65535.
REQ-002: Parameter C1_INVERT, default 1: 1 makes c1 the inverted reference (180 deg SDRAM clock); 0 makes c1 in phase with the reference.
REQ-003: Port inclk0, input, 1 bit: the single reference clock; all registers use its rising edge.
REQ-004: Port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005: Port c0, output, 1 bit: fast system clock, an unconditional copy of inclk0.
REQ-006: Port c1, output, 1 bit: SDRAM clock, a copy of inclk0 (inverted per C1_INVERT), gated by locked.
REQ-007: Port c2, output, 1 bit: registered inclk0/4 clock, 50% duty.
REQ-008: Port clk7, output, 1 bit: registered inclk0/16 clock, 50% duty.
REQ-009: Port c2_en, output, 1 bit: one-inclk0-cycle enable pulse, once per c2 period.
REQ-010: Port clk7_en, output, 1 bit: one-inclk0-cycle enable pulse, once per clk7 period.
REQ-011: Port locked, output, 1 bit: high once the lock interval has elapsed.

Function
REQ-012: Lock counter, 16 bits: cleared by reset; increments on each inclk0 rising edge while locked=0; saturates once locked is set.
REQ-013: locked is registered and sets on the edge where the lock counter reaches LOCK_CYCLES-1. This makes locked first high after exactly LOCK_CYCLES edges following reset release.
REQ-014: Once set, locked stays high until reset_n is asserted.
REQ-015: Divider counter div_cnt, 4 bits: held at 0 while locked=0. Once locked=1, it increments by 1 on every inclk0 edge and wraps from 15 to 0 with no gap.
REQ-016: c2 = div_cnt[1] and clk7 = div_cnt[3]. Both are register outputs and glitch-free.
REQ-017: c2_en = locked AND (div_cnt[1:0] = 3), which is a combinational decode of registered state.
REQ-018: clk7_en = locked AND (div_cnt = 15).
REQ-019: c1 = (inclk0 XOR C1_INVERT) AND locked. It is the only combinational clock path besides c0.
REQ-020: c0 toggles even during reset and before lock.
REQ-021: c2_en and clk7_en are coincident when div_cnt = 15.
REQ-022: The first c2 rising edge occurs 2 edges after locked rises. The first clk7 rising edge occurs 8 edges after locked rises.

Reset
REQ-023: While reset_n=0, all of the following hold immediately and asynchronously: lock counter=0, locked=0, div_cnt=0, c1=0, c2=0, clk7=0, c2_en=0, clk7_en=0.
REQ-024: Reset released mid-operation restarts the full lock interval; no divider phase is retained.
REQ-025: Reset deassertion is sampled on the next inclk0 rising edge; the counting edge sequence starts from that edge.

Verification
REQ-026: Reset with LOCK_CYCLES=256, release, count edges -> locked=0 through edge 255 and locked=1 after edge 256; c1, c2 and clk7 stay 0 before lock.
REQ-027: After lock, run 64 edges -> c2 has period 4 (2 high, 2 low) and clk7 has period 16 (8 high, 8 low). c2_en pulses 16 times and clk7_en pulses 4 times, each pulse 1 cycle wide.
REQ-028: After lock, observe pulse alignment -> c2_en is high exactly when div_cnt[1:0]=3, clk7_en is high only when div_cnt=15, and both are high together every 16th edge.
REQ-029: After lock, assert reset_n asynchronously between edges -> all outputs except c0 drop to 0 without waiting for an edge. After release, locked returns only after another 256 edges.
REQ-030: Check C1_INVERT=1 and C1_INVERT=0 after lock -> c1 is the inverse of inclk0 when 1 and equal to inclk0 when 0. With C1_INVERT=1 and locked=0, c1 is 0.
REQ-031: Set LOCK_CYCLES=1 -> locked=1 after the first edge following reset release, and div_cnt starts counting on the next edge.

Source files
------------

// File: rtl/pll_clockgen.sv
// Reference-clock generator: lock-delay counter, divide-by-4/16 clocks with
// matching enable pulses, and pass-through / gated copies of the reference.
module pll_clockgen #(
    parameter int unsigned LOCK_CYCLES = 256,
    parameter bit          C1_INVERT   = 1'b1
) (
    input  logic inclk0,
    input  logic reset_n,
    output logic c0,
    output logic c1,
    output logic c2,
    output logic clk7,
    output logic c2_en,
    output logic clk7_en,
    output logic locked
);

    localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);

    logic [15:0] r_lock_cnt;
    logic        r_locked;
    logic [3:0]  r_div_cnt;
    logic        w_ref_phase;

    // The counter freezes once locked, so it never wraps back into a re-lock.
    always_ff @(posedge inclk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_lock_cnt <= 16'd0;
            r_locked   <= 1'b0;
        end else if (!r_locked) begin
            r_lock_cnt <= r_lock_cnt + 16'd1;
            if (r_lock_cnt == LOCK_LAST) begin
                r_locked <= 1'b1;
            end
        end
    end

    // Divider starts on the edge after lock, so c2 first rises two edges later.
    always_ff @(posedge inclk0 or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= 4'd0;
        end else if (r_locked) begin
            r_div_cnt <= r_div_cnt + 4'd1;
        end
    end

    assign w_ref_phase = inclk0 ^ C1_INVERT;

    assign c0      = inclk0;
    assign c1      = w_ref_phase & r_locked;
    assign c2      = r_div_cnt[1];
    assign clk7    = r_div_cnt[3];
    assign c2_en   = r_locked & (r_div_cnt[1:0] == 2'd3);
    assign clk7_en = r_locked & (r_div_cnt == 4'd15);
    assign locked  = r_locked;

endmodule

// File: tb/tb_pll_clockgen.sv
// Bench for pll_clockgen: two instances (default lock/inverted c1, and
// single-edge lock/non-inverted c1) checked against an edge-count model.
module tb_pll_clockgen;

  localparam int A_LOCK = 256;
  localparam int A_INV  = 1;
  localparam int B_LOCK = 1;
  localparam int B_INV  = 0;

  logic inclk0;
  logic reset_n;

  logic a_c0, a_c1, a_c2, a_clk7, a_c2_en, a_clk7_en, a_locked;
  logic b_c0, b_c1, b_c2, b_clk7, b_c2_en, b_clk7_en, b_locked;

  int checks;
  int errors;
  int n_edges;
  bit cmp_en;

  pll_clockgen #(.LOCK_CYCLES(A_LOCK), .C1_INVERT(1'b1)) dut_a (
    .inclk0(inclk0), .reset_n(reset_n),
    .c0(a_c0), .c1(a_c1), .c2(a_c2), .clk7(a_clk7),
    .c2_en(a_c2_en), .clk7_en(a_clk7_en), .locked(a_locked)
  );

  pll_clockgen #(.LOCK_CYCLES(B_LOCK), .C1_INVERT(1'b0)) dut_b (
    .inclk0(inclk0), .reset_n(reset_n),
    .c0(b_c0), .c1(b_c1), .c2(b_c2), .clk7(b_clk7),
    .c2_en(b_c2_en), .clk7_en(b_clk7_en), .locked(b_locked)
  );

  // clock / reset
  initial begin
    inclk0 = 1'b0;
    forever #5 inclk0 = ~inclk0;
  end

  // model: edges counted since reset release
  always @(posedge inclk0 or negedge reset_n) begin
    if (!reset_n) n_edges <= 0;
    else          n_edges <= n_edges + 1;
  end

  // expected {locked, c2, clk7, c2_en, clk7_en} after n edges with lock length lk
  function automatic logic [4:0] model(input int n, input int lk);
    int ph;
    logic lkd;
    lkd = (n >= lk);
    ph  = lkd ? ((n - lk) % 16) : 0;
    return {lkd, ((ph % 4) >= 2), (ph >= 8), (lkd && (ph % 4) == 3), (lkd && ph == 15)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare both instances against the model on every clock phase
  always @(inclk0) begin
    #1;
    if (cmp_en) begin
      logic [4:0] ea, eb;
      logic ref_clk;
      ref_clk = inclk0;
      ea = model(n_edges, A_LOCK);
      eb = model(n_edges, B_LOCK);
      check("a_state", {a_locked, a_c2, a_clk7, a_c2_en, a_clk7_en}, ea);
      check("b_state", {b_locked, b_c2, b_clk7, b_c2_en, b_clk7_en}, eb);
      check("a_c0", a_c0, ref_clk);
      check("b_c0", b_c0, ref_clk);
      check("a_c1", a_c1, (ref_clk ^ 1'(A_INV)) & ea[4]);
      check("b_c1", b_c1, (ref_clk ^ 1'(B_INV)) & eb[4]);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge inclk0);
    #1;
  endtask

  task automatic release_reset();
    @(posedge inclk0);
    #3;
    reset_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {a_locked, a_c1, a_c2, a_clk7, a_c2_en, a_clk7_en,
                 b_locked, b_c1, b_c2, b_clk7, b_c2_en, b_clk7_en}, 12'h000);
  endtask

  initial begin
    int c2_en_cnt, clk7_en_cnt, c2_hi, clk7_hi;
    checks  = 0;
    errors  = 0;
    cmp_en  = 1'b0;
    reset_n = 1'b0;
    #2 cmp_en = 1'b1;

    repeat (3) tick();
    check_all_zero("reset_zero");

    // release, then pin lock timing with literal expectations
    release_reset();
    tick();
    check("b_locked_edge1", b_locked, 1'b1);
    check("b_c2_edge1", b_c2, 1'b0);
    check("a_c1_prelock", a_c1, 1'b0);
    tick();
    check("b_c2_edge2", b_c2, 1'b0);
    tick();
    check("b_c2_edge3", b_c2, 1'b1);
    repeat (252) tick();
    check("a_locked_edge255", a_locked, 1'b0);
    check("a_c2_prelock", {a_c2, a_clk7}, 2'b00);
    tick();
    check("a_locked_edge256", a_locked, 1'b1);
    check("a_div_start", {a_c2, a_clk7, a_c2_en, a_clk7_en}, 4'b0000);
    tick();
    tick();
    check("a_c2_first_rise", a_c2, 1'b1);
    repeat (6) tick();
    check("a_clk7_first_rise", {a_clk7, a_c2_en, a_clk7_en}, 3'b100);
    repeat (7) tick();
    check("a_both_en", {a_c2_en, a_clk7_en}, 2'b11);

    // 64 edges: pulse and duty counts
    c2_en_cnt = 0; clk7_en_cnt = 0; c2_hi = 0; clk7_hi = 0;
    repeat (64) begin
      tick();
      c2_en_cnt   += int'(a_c2_en);
      clk7_en_cnt += int'(a_clk7_en);
      c2_hi       += int'(a_c2);
      clk7_hi     += int'(a_clk7);
    end
    check("c2_en_pulses", c2_en_cnt, 16);
    check("clk7_en_pulses", clk7_en_cnt, 4);
    check("c2_high_cycles", c2_hi, 32);
    check("clk7_high_cycles", clk7_hi, 32);

    // c1 polarity in the high phase after lock
    @(posedge inclk0);
    #2;
    check("a_c1_inverted", a_c1, 1'b0);
    check("b_c1_inphase", b_c1, 1'b1);

    // random async resets mid-cycle, random run lengths
    for (int it = 0; it < 4; it++) begin
      tick();
      #($urandom_range(1, 3));
      reset_n = 1'b0;
      #1;
      check_all_zero("async_reset_zero");
      check("c0_in_reset", a_c0, inclk0);
      repeat ($urandom_range(1, 4)) tick();
      release_reset();
      repeat ($urandom_range(20, 400)) tick();
    end

    // after a reset the full lock interval is needed again
    tick();
    reset_n = 1'b0;
    repeat (2) tick();
    release_reset();
    repeat (255) tick();
    check("relock_edge255", a_locked, 1'b0);
    tick();
    check("relock_edge256", a_locked, 1'b1);
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
